// File: rtl/zx_pager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : zx_pager                                                      |
// | Purpose  : Spectrum memory-paging controller. Decodes CPU writes to the  |
// |            7FFD / 1FFD paging ports, holds the paging state and maps     |
// |            each CPU access (a[15:14]) onto a ROM or RAM bank number.     |
// | Params   : RAM_BITS (3..6) RAM bank number width, 128K..1024K            |
// |            MODE 0 = 128K, 1 = +2A/+3, 2 = Pentagon extended              |
// | Ports    : clock, reset (sync, active high)                              |
// |            iorq, wr, m1 (active low CPU strobes), a[15:0], di[7:0]       |
// |            romPage, ramPage, vmmPage, locked, special, motor (registered)|
// |            bank, isRom (combinational from state and a[15:14])           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module zx_pager #(
    parameter int RAM_BITS = 3,
    parameter int MODE     = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iorq,
    input  logic                wr,
    input  logic                m1,
    input  logic [15:0]         a,
    input  logic [7:0]          di,
    output logic [1:0]          romPage,
    output logic [RAM_BITS-1:0] ramPage,
    output logic                vmmPage,
    output logic                locked,
    output logic                special,
    output logic                motor,
    output logic [RAM_BITS-1:0] bank,
    output logic                isRom
);

    generate
        if (RAM_BITS < 3 || RAM_BITS > 6) begin : g_badRamBits
            $error("zx_pager: RAM_BITS must be in 3..6");
        end
        if (MODE < 0 || MODE > 2) begin : g_badMode
            $error("zx_pager: MODE must be 0, 1 or 2");
        end
    endgenerate

    // In the 1024K Pentagon configuration 7FFD bit 5 is a page bit, so the
    // lock feature disappears.
    localparam bit c_NO_LOCK = (MODE == 2) && (RAM_BITS == 6);

    logic [7:0] r_reg7;
    logic [3:0] r_reg1;     // {motor, cfg[1:0], special}
    logic       r_prevStb;

    logic       w_ioWr;
    logic       w_p7;
    logic       w_p1;
    logic       w_ioStb;
    logic       w_load;
    logic [1:0] w_cfg;
    logic [2:0] w_bank3;
    logic       w_useRamPage;

    // An I/O cycle with m1 low is an interrupt acknowledge, never a write.
    assign w_ioWr = !iorq && !wr && m1;

    generate
        if (MODE == 1) begin : g_decodePlus3
            assign w_p7 = (a[15:14] == 2'b01) && !a[1];
            assign w_p1 = (a[15:12] == 4'b0001) && !a[1];
        end else begin : g_decode128
            assign w_p7 = !a[15] && !a[1];
            assign w_p1 = 1'b0;
        end
    endgenerate

    assign w_ioStb = w_ioWr && (w_p7 || w_p1);
    // Edge-detect so a strobe held over several clocks loads only once; the
    // lock is checked against the state before this write.
    assign w_load  = w_ioStb && !r_prevStb && !locked;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_reg7    <= 8'h00;
            r_reg1    <= 4'h0;
            // Preset high so a strobe already active at reset release is
            // not mistaken for a fresh one.
            r_prevStb <= 1'b1;
        end else begin
            r_prevStb <= w_ioStb;
            if (w_load && w_p7) begin
                r_reg7 <= di;
            end
            if (w_load && w_p1) begin
                r_reg1 <= di[3:0];
            end
        end
    end

    // 7FFD bits 6, 7, 5 extend the bank number in Pentagon mode, in that
    // order of significance from bit 3 upwards.
    generate
        if (RAM_BITS == 3) begin : g_ramNarrow
            assign ramPage = r_reg7[2:0];
        end else begin : g_ramWide
            logic [2:0] w_ext;
            assign w_ext   = (MODE == 2) ? {r_reg7[5], r_reg7[7], r_reg7[6]} : 3'b000;
            assign ramPage = {w_ext[RAM_BITS-4:0], r_reg7[2:0]};
        end
    endgenerate

    assign vmmPage = r_reg7[3];
    assign locked  = c_NO_LOCK ? 1'b0 : r_reg7[5];
    assign romPage = {(MODE == 1) ? r_reg1[2] : 1'b0, r_reg7[4]};
    assign special = (MODE == 1) ? r_reg1[0] : 1'b0;
    assign motor   = (MODE == 1) ? r_reg1[3] : 1'b0;
    assign w_cfg   = r_reg1[2:1];

    always_comb begin
        w_bank3      = 3'd0;
        w_useRamPage = 1'b0;
        isRom        = 1'b0;
        if (special) begin
            unique case (w_cfg)
                2'd0: w_bank3 = {1'b0, a[15:14]};
                2'd1: w_bank3 = {1'b1, a[15:14]};
                2'd2: w_bank3 = (a[15:14] == 2'b11) ? 3'd3 : {1'b1, a[15:14]};
                default: begin
                    unique case (a[15:14])
                        2'b00:   w_bank3 = 3'd4;
                        2'b01:   w_bank3 = 3'd7;
                        2'b10:   w_bank3 = 3'd6;
                        default: w_bank3 = 3'd3;
                    endcase
                end
            endcase
        end else begin
            unique case (a[15:14])
                2'b00:   isRom        = 1'b1;
                2'b01:   w_bank3      = 3'd5;
                2'b10:   w_bank3      = 3'd2;
                default: w_useRamPage = 1'b1;
            endcase
        end
    end

    assign bank = w_useRamPage ? ramPage : RAM_BITS'(w_bank3);

endmodule
`default_nettype wire

// File: tb/tb_zx_pager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_zx_pager                                                   |
// | Purpose  : Directed self-checking bench for zx_pager. Four instances     |
// |            (128K, Pentagon 512K, Pentagon 1024K, +3) share one CPU bus.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_zx_pager;

    logic        clock = 1'b0;
    logic        reset;
    logic        iorq;
    logic        wr;
    logic        m1;
    logic [15:0] a;
    logic [7:0]  di;

    int checks = 0;
    int errors = 0;

    // 128K
    logic [1:0] u0RomPage;  logic [2:0] u0RamPage;  logic u0Vmm, u0Locked, u0Special, u0Motor;
    logic [2:0] u0Bank;     logic u0IsRom;
    // Pentagon 512K
    logic [1:0] u5RomPage;  logic [4:0] u5RamPage;  logic u5Vmm, u5Locked, u5Special, u5Motor;
    logic [4:0] u5Bank;     logic u5IsRom;
    // Pentagon 1024K
    logic [1:0] u6RomPage;  logic [5:0] u6RamPage;  logic u6Vmm, u6Locked, u6Special, u6Motor;
    logic [5:0] u6Bank;     logic u6IsRom;
    // +2A/+3
    logic [1:0] u1RomPage;  logic [2:0] u1RamPage;  logic u1Vmm, u1Locked, u1Special, u1Motor;
    logic [2:0] u1Bank;     logic u1IsRom;

    zx_pager #(.RAM_BITS(3), .MODE(0)) u0 (
        .clock(clock), .reset(reset), .iorq(iorq), .wr(wr), .m1(m1), .a(a), .di(di),
        .romPage(u0RomPage), .ramPage(u0RamPage), .vmmPage(u0Vmm), .locked(u0Locked),
        .special(u0Special), .motor(u0Motor), .bank(u0Bank), .isRom(u0IsRom));

    zx_pager #(.RAM_BITS(5), .MODE(2)) u5 (
        .clock(clock), .reset(reset), .iorq(iorq), .wr(wr), .m1(m1), .a(a), .di(di),
        .romPage(u5RomPage), .ramPage(u5RamPage), .vmmPage(u5Vmm), .locked(u5Locked),
        .special(u5Special), .motor(u5Motor), .bank(u5Bank), .isRom(u5IsRom));

    zx_pager #(.RAM_BITS(6), .MODE(2)) u6 (
        .clock(clock), .reset(reset), .iorq(iorq), .wr(wr), .m1(m1), .a(a), .di(di),
        .romPage(u6RomPage), .ramPage(u6RamPage), .vmmPage(u6Vmm), .locked(u6Locked),
        .special(u6Special), .motor(u6Motor), .bank(u6Bank), .isRom(u6IsRom));

    zx_pager #(.RAM_BITS(3), .MODE(1)) u1 (
        .clock(clock), .reset(reset), .iorq(iorq), .wr(wr), .m1(m1), .a(a), .di(di),
        .romPage(u1RomPage), .ramPage(u1RamPage), .vmmPage(u1Vmm), .locked(u1Locked),
        .special(u1Special), .motor(u1Motor), .bank(u1Bank), .isRom(u1IsRom));

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One OUT cycle with the strobe held for n clocks, then one idle clock.
    task automatic ioWrite(input logic [15:0] addr, input logic [7:0] data, input int n);
        a    = addr;
        di   = data;
        iorq = 1'b0;
        wr   = 1'b0;
        m1   = 1'b1;
        repeat (n) tick();
        iorq = 1'b1;
        wr   = 1'b1;
        tick();
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        iorq  = 1'b1;
        wr    = 1'b1;
        m1    = 1'b1;
        a     = 16'h0000;
        di    = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_romPage", u0RomPage, 0);
        chk("rst_ramPage", u0RamPage, 0);
        chk("rst_vmmPage", u0Vmm, 0);
        chk("rst_locked",  u0Locked, 0);
        chk("rst_special", u1Special, 0);
        chk("rst_motor",   u1Motor, 0);
        chk("rst_bank0",   u0Bank, 0);
        chk("rst_isRom0",  u0IsRom, 1);

        // OUT (7FFD),0x17 held 3 clocks; di changes mid-strobe must not reload
        a = 16'h7FFD; di = 8'h17; iorq = 1'b0; wr = 1'b0;
        tick();
        di = 8'h08;
        tick();
        tick();
        iorq = 1'b1; wr = 1'b1;
        tick();
        chk("w17_ramPage", u0RamPage, 7);
        chk("w17_romPage", u0RomPage, 1);
        chk("w17_vmmPage", u0Vmm, 0);
        chk("w17_locked",  u0Locked, 0);
        a = 16'hC000; #1;
        chk("w17_bankC000", u0Bank, 7);
        chk("w17_isRomC000", u0IsRom, 0);
        a = 16'h4000; #1;
        chk("bank4000", u0Bank, 5);
        a = 16'h8000; #1;
        chk("bank8000", u0Bank, 2);

        // Lock
        pulseReset();
        ioWrite(16'h7FFD, 8'h21, 1);
        chk("lock_ramPage1", u0RamPage, 1);
        chk("lock_locked",   u0Locked, 1);
        ioWrite(16'h7FFD, 8'h07, 1);
        chk("lock_ignored", u0RamPage, 1);
        ioWrite(16'h1FFD, 8'h01, 1);
        chk("lock_1ffd_ignored", u1Special, 0);
        reset = 1'b1;
        tick();
        chk("lockrst_ramPage", u0RamPage, 0);
        chk("lockrst_locked",  u0Locked, 0);
        chk("lockrst_romPage", u0RomPage, 0);
        reset = 1'b0;
        tick();
        ioWrite(16'h7FFD, 8'h03, 1);
        chk("postrst_accept", u0RamPage, 3);

        // Reset released while a strobe is held: no load
        reset = 1'b1; a = 16'h7FFD; di = 8'h06; iorq = 1'b0; wr = 1'b0;
        tick();
        chk("rstwin_ramPage", u0RamPage, 0);
        reset = 1'b0;
        tick();
        tick();
        iorq = 1'b1; wr = 1'b1;
        tick();
        chk("rstrel_noload", u0RamPage, 0);

        // Interrupt acknowledge with a matching address: no load
        a = 16'h7FFD; di = 8'h05; m1 = 1'b0; iorq = 1'b0; wr = 1'b0;
        tick();
        tick();
        iorq = 1'b1; wr = 1'b1; m1 = 1'b1;
        tick();
        chk("intack_noload", u0RamPage, 0);

        // 128K: 1FFD address is a 7FFD write; non-matching addresses ignored
        ioWrite(16'h1FFD, 8'h02, 1);
        chk("m0_1ffd_as_7ffd", u0RamPage, 2);
        ioWrite(16'h7FFF, 8'h04, 1);
        chk("nomatch_a1", u0RamPage, 2);
        ioWrite(16'hFFFD, 8'h04, 1);
        chk("nomatch_a15", u0RamPage, 2);

        // Pentagon 512K / 1024K
        pulseReset();
        ioWrite(16'h7FFD, 8'hC3, 1);
        chk("p5_ramPage", u5RamPage, 27);
        chk("p5_locked",  u5Locked, 0);
        chk("p6_ramPage", u6RamPage, 27);
        chk("m0_noext",   u0RamPage, 3);
        a = 16'hC000; #1;
        chk("p5_bankC000",  u5Bank, 27);
        chk("p5_isRomC000", u5IsRom, 0);
        pulseReset();
        ioWrite(16'h7FFD, 8'h20, 1);
        chk("p6_ramPage32", u6RamPage, 32);
        chk("p6_nolock",    u6Locked, 0);
        chk("p5_locks",     u5Locked, 1);
        ioWrite(16'h7FFD, 8'h01, 1);
        chk("p6_ramPage1",  u6RamPage, 1);
        chk("p5_stays",     u5RamPage, 0);

        // +3 special mapping, cfg 2
        pulseReset();
        ioWrite(16'h1FFD, 8'h05, 1);
        chk("p3_special", u1Special, 1);
        a = 16'h0000; #1;
        chk("p3_c2_q0", u1Bank, 4);
        chk("p3_c2_rom", u1IsRom, 0);
        a = 16'h4000; #1;
        chk("p3_c2_q1", u1Bank, 5);
        a = 16'h8000; #1;
        chk("p3_c2_q2", u1Bank, 6);
        a = 16'hC000; #1;
        chk("p3_c2_q3", u1Bank, 3);
        chk("p3_c2_romq3", u1IsRom, 0);
        ioWrite(16'h1FFD, 8'h07, 1);
        a = 16'h4000; #1;
        chk("p3_c3_q1", u1Bank, 7);
        ioWrite(16'h1FFD, 8'h03, 1);
        a = 16'h0000; #1;
        chk("p3_c1_q0", u1Bank, 4);
        ioWrite(16'h1FFD, 8'h01, 1);
        a = 16'hC000; #1;
        chk("p3_c0_q3", u1Bank, 3);
        ioWrite(16'h1FFD, 8'h0C, 1);
        chk("p3_special0", u1Special, 0);
        chk("p3_motor",    u1Motor, 1);
        chk("p3_romPage",  u1RomPage, 2);
        a = 16'h0000; #1;
        chk("p3_isRom", u1IsRom, 1);
        chk("m0_romHi0", u0RomPage[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zx_pager.md
Name: zx_pager

Overview:
- Parametrised Spectrum memory-paging controller; successor to the fixed 128K port-7FFD latch.
- Decodes CPU I/O writes to the paging ports and holds the paging state.
- Resolves each CPU memory access into a ROM or RAM bank number for the mem block.
- Modes: 128K, +2A/+3 (adds port 1FFD and all-RAM special mapping) and Pentagon extended RAM (up to 1024K).

Parameters:
- RAM_BITS, 3, width of RAM bank number; legal range 3..6, giving 128K..1024K.
- MODE, 0, 0 = 128K, 1 = +2A/+3, 2 = Pentagon extended.

Ports:
- clock  in  1  CPU clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- iorq  in  1  CPU IORQ, active low.
- wr  in  1  CPU WR, active low.
- m1  in  1  CPU M1, active low; an I/O cycle with m1 low is an interrupt acknowledge, not a port write.
- a  in  16  CPU address.
- di  in  8  CPU data out.
- romPage  out  2  ROM select; bit 1 is always 0 unless MODE=1.
- ramPage  out  RAM_BITS  bank mapped at C000-FFFF in normal mapping.
- vmmPage  out  1  video page select: 0 = bank 5, 1 = bank 7.
- locked  out  1  paging lock state.
- special  out  1  +3 all-RAM mapping active.
- motor  out  1  +3 disk motor, 1FFD bit 3.
- bank  out  RAM_BITS  bank for current address a[15:14].
- isRom  out  1  current access targets ROM.

Behaviour:
- Port decode, all qualified with !iorq && !wr && m1:
  - MODE 0 and 2: p7 = !a[15] && !a[1].
  - MODE 1: p7 = (a[15:14]==2'b01) && !a[1]; p1 = (a[15:12]==4'b0001) && !a[1].
  - p1 is never asserted outside MODE 1.
- Write strobe: ioStb = decode true. Registers load once per I/O cycle, on the first clock where ioStb is high and prevStb was low. prevStb is a register sampling ioStb every clock. A strobe held for N cycles gives exactly one load.
- Reset:
  - Sets: reg7 = 0, reg1 = 0, prevStb = 1.
  - Outputs after reset: romPage = 0, ramPage = 0, vmmPage = 0, locked = 0, special = 0, motor = 0.
  - A strobe already active when reset deasserts is not taken; the next edge is taken.
  - Reset asserted during a strobe wins.
- Lock:
  - When locked = 1, writes to both 7FFD and 1FFD are ignored until reset.
  - The write that sets the lock bit is itself applied in full.
  - locked = reg7[5], except MODE=2 with RAM_BITS=6: reg7[5] is a page bit and locked is constant 0.
- 7FFD fields:
  - ramPage[2:0] = di[2:0]; vmmPage = di[3]; romPage[0] = di[4].
  - MODE 2, RAM_BITS>=4: ramPage[3] = di[6].
  - MODE 2, RAM_BITS>=5: ramPage[4] = di[7].
  - MODE 2, RAM_BITS=6: ramPage[5] = di[5].
  - In every other case ramPage bits above 2 are 0.
- 1FFD fields (MODE 1):
  - special = di[0]; romPage[1] = di[2]; motor = di[3]; cfg = di[2:1].
  - When special = 1, romPage[1] is still held but has no effect on mapping.
- Timing: all outputs are registered, except bank and isRom. Register updates are visible the clock after the load edge.
- Mapping (combinational from registers and a[15:14]):
  - Normal mapping:
    - 00: isRom = 1, bank = 0.
    - 01: bank = 5.
    - 10: bank = 2.
    - 11: bank = ramPage.
  - Special mapping (special = 1), cfg selects banks for quadrants 0..3:
    - cfg 0: 0,1,2,3.
    - cfg 1: 4,5,6,7.
    - cfg 2: 4,5,6,3.
    - cfg 3: 4,7,6,3.
    - isRom = 0 for all quadrants.
  - Bank numbers are zero-extended to RAM_BITS.
- A write whose decode matches neither port changes nothing. There is no readback path; the ports are write-only.
- Illegal RAM_BITS (<3 or >6) is an elaboration error.

Test Plan:
- MODE 0, RAM_BITS 3: reset, then OUT (7FFD),0x17 with strobe held 3 cycles.
  - Required: ramPage = 7, romPage = 1, vmmPage = 0, locked = 0.
  - The register loads exactly once (verified by changing di mid-strobe).
- Lock, MODE 0: OUT 0x21 then OUT 0x07.
  - Required: after the first write ramPage = 1, locked = 1.
  - The second write is ignored and ramPage stays 1.
  - Assert reset: all outputs return to 0 and a new write is accepted.
- MODE 2, RAM_BITS 5: OUT (7FFD),0xC3.
  - Required: ramPage = 5'b11011, locked = 0.
  - With a = 0xC000: bank = 27, isRom = 0.
- MODE 2, RAM_BITS 6: OUT 0x20 then OUT 0x01.
  - Required: after the first write ramPage = 32 and locked stays 0.
  - The second write is accepted, giving ramPage = 1.
- MODE 1: OUT (1FFD),0x05 (special, cfg = 2).
  - Required: sweeping a = 0000/4000/8000/C000 gives bank = 4/5/6/3, isRom = 0.
  - Then OUT (1FFD),0x0C: special = 0, motor = 1, romPage[1] = 1; a = 0000 gives isRom = 1.
- Boundaries:
  - Reset released while a strobe is held: no load.
  - Interrupt acknowledge (m1 low, iorq low) with a matching address: no load.
  - MODE 0 write to 1FFD address (a = 0x1FFD): acts as a 7FFD write (a[15] = 0, a[1] = 0).
